// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and sizing helper for the binary-to-BCD converter
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } bcd_state_t;

    // Decimal digits needed for any in_w-bit value (log10(2) ~= 0.301).
    function automatic int bcd_full_digits(input int in_w);
        return (in_w * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// rtl/bin_to_bcd_if.sv - handshake and result bundle between an upstream source and bin_to_bcd
interface bin_to_bcd_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 2
);
    logic [IN_W-1:0]     i_bin;
    logic                i_valid;
    logic                o_ready;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_valid;
    logic                o_overflow;

    modport master (
        output i_bin,
        output i_valid,
        input  o_ready,
        input  o_bcd,
        input  o_valid,
        input  o_overflow
    );

    modport slave (
        input  i_bin,
        input  i_valid,
        output o_ready,
        output o_bcd,
        output o_valid,
        output o_overflow
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational double-dabble digit correction (add 3 when >= 5)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble binary-to-packed-BCD converter
// Optional BIN_TO_BCD_SATURATE_EN: on overflow present all-nines instead of the low digits.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    bin_to_bcd_if.slave  bus
);

    localparam int FULL_DIGITS = bcd_full_digits(IN_W);
    localparam int SW          = BCD_DIGIT_W * FULL_DIGITS;
    localparam int OW          = BCD_DIGIT_W * DIGITS;
    localparam int CW          = $clog2(IN_W + 1);

    bcd_state_t          state, next_state;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [IN_W-1:0]     shreg;
    logic [CW-1:0]       cnt;
    logic [SW+IN_W-1:0]  shifted;
    logic [OW-1:0]       low_digits;
    logic [OW-1:0]       bcd_next;
    logic                ovf_next;
    logic [OW-1:0]       bcd_q;
    logic                valid_q;
    logic                ovf_q;

    for (genvar d = 0; d < FULL_DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted = {adj, shreg} << 1;

    // Digits beyond the presented width only exist when the input can exceed 10^DIGITS-1.
    if (FULL_DIGITS > DIGITS) begin : g_trunc
        assign low_digits = scratch[OW-1:0];
        assign ovf_next   = |scratch[SW-1:OW];
    end else if (FULL_DIGITS == DIGITS) begin : g_exact
        assign low_digits = scratch;
        assign ovf_next   = 1'b0;
    end else begin : g_ext
        assign low_digits = {{(OW-SW){1'b0}}, scratch};
        assign ovf_next   = 1'b0;
    end

`ifdef BIN_TO_BCD_SATURATE_EN
    assign bcd_next = ovf_next ? {DIGITS{4'h9}} : low_digits;
`else
    assign bcd_next = low_digits;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.i_valid) next_state = ST_SHIFT;
            ST_SHIFT: if (cnt == '0)   next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Result registers load on the edge entering DONE, so o_valid coincides with DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        shreg   <= bus.i_bin;
                        scratch <= '0;
                        cnt     <= CW'(IN_W);
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        scratch <= shifted[SW+IN_W-1 -: SW];
                        shreg   <= shifted[IN_W-1:0];
                        cnt     <= cnt - 1'b1;
                    end else begin
                        bcd_q   <= bcd_next;
                        ovf_q   <= ovf_next;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready    = (state == ST_IDLE);
    assign bus.o_bcd      = bcd_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb/tb_bin_to_bcd.sv - directed self-checking bench for bin_to_bcd (8-bit/2-digit and 16-bit/5-digit)
module tb_bin_to_bcd;

    logic clk;
    logic rst;

    bin_to_bcd_if #(.IN_W(8),  .DIGITS(2)) b8  ();
    bin_to_bcd_if #(.IN_W(16), .DIGITS(5)) b16 ();

    bin_to_bcd #(.IN_W(8), .DIGITS(2)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b8.slave)
    );

    bin_to_bcd #(.IN_W(16), .DIGITS(5)) u_dut16 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses8 = 0;

    logic [7:0] got_bcd;
    logic       got_ovf;
    int         lat;
    int         busy;

    always @(negedge clk) if (b8.o_valid) pulses8++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake one value on the 8-bit DUT, then measure latency, busy span and result.
    task automatic send8(input logic [7:0] v);
        int n;
        n = 0;
        while (!b8.o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        b8.i_bin   = v;
        b8.i_valid = 1'b1;
        @(posedge clk); #1;
        b8.i_valid = 1'b0;
        lat  = -1;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (b8.o_valid && lat < 0) begin
                lat     = k;
                got_bcd = b8.o_bcd;
                got_ovf = b8.o_overflow;
            end
            if (b8.o_ready) break;
            busy++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int p0;
        int lat16;
        logic [19:0] bcd16;
        logic        ovf16;
        logic [7:0]  exp_bcd;

        rst = 1'b1;
        b8.i_bin = '0;  b8.i_valid = 1'b0;
        b16.i_bin = '0; b16.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", b8.o_ready, 1);
        check("rst_bcd",   b8.o_bcd, 0);
        check("rst_valid", b8.o_valid, 0);
        check("rst_ovf",   b8.o_overflow, 0);
        check("rst_ready16", b16.o_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        p0 = pulses8;
        send8(8'd42);
        check("lat42",  lat, 9);
        check("busy42", busy, 10);
        check("bcd42",  got_bcd, 8'h42);
        check("ovf42",  got_ovf, 0);
        check("pulse42", pulses8 - p0, 1);

        for (int v = 0; v < 100; v++) begin
            exp_bcd = {4'(v / 10), 4'(v % 10)};
            send8(8'(v));
            check($sformatf("sweep_bcd%0d", v), got_bcd, exp_bcd);
            check($sformatf("sweep_ovf%0d", v), got_ovf, 0);
        end

        send8(8'd100);
`ifdef BIN_TO_BCD_SATURATE_EN
        check("bcd100", got_bcd, 8'h99);
`else
        check("bcd100", got_bcd, 8'h00);
`endif
        check("ovf100", got_ovf, 1);
        send8(8'd255);
`ifdef BIN_TO_BCD_SATURATE_EN
        check("bcd255", got_bcd, 8'h99);
`else
        check("bcd255", got_bcd, 8'h55);
`endif
        check("ovf255", got_ovf, 1);
        check("ovf_hold", b8.o_overflow, 1);

        // Value offered while busy must be dropped.
        p0 = pulses8;
        @(negedge clk);
        b8.i_bin = 8'd7; b8.i_valid = 1'b1;
        @(negedge clk);
        b8.i_bin = 8'd88;
        repeat (5) @(negedge clk);
        b8.i_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("drop_pulses", pulses8 - p0, 1);
        check("drop_bcd", b8.o_bcd, 8'h07);
        check("drop_ready", b8.o_ready, 1);

        // Reset four cycles into a conversion aborts it.
        p0 = pulses8;
        @(negedge clk);
        b8.i_bin = 8'd63; b8.i_valid = 1'b1;
        @(posedge clk); #1;
        b8.i_valid = 1'b0;
        check("abort_busy", b8.o_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", b8.o_ready, 1);
        check("abort_bcd", b8.o_bcd, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_pulses", pulses8 - p0, 0);
        send8(8'd12);
        check("bcd12", got_bcd, 8'h12);
        check("lat12", lat, 9);

        // 16-bit / 5-digit variant at full scale.
        @(negedge clk);
        b16.i_bin = 16'hFFFF; b16.i_valid = 1'b1;
        @(posedge clk); #1;
        b16.i_valid = 1'b0;
        lat16 = -1;
        bcd16 = '0;
        ovf16 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (b16.o_valid && lat16 < 0) begin
                lat16 = k;
                bcd16 = b16.o_bcd;
                ovf16 = b16.o_overflow;
            end
            if (b16.o_ready) break;
            @(posedge clk); #1;
        end
        check("lat16", lat16, 17);
        check("bcd16", bcd16, 20'h65535);
        check("ovf16", ovf16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits.
- Sits directly upstream of the two-digit seven-segment driver: its o_bcd feeds the driver's 8-bit data input, so each nibble is a decimal digit 0-9.
- Accepts one value per valid/ready handshake, runs one shift per clock, then presents a held result with a one-cycle o_valid pulse.

Parameters:
- IN_W, 8, width of the binary input.
- DIGITS, 2, number of BCD digits presented on o_bcd (output width 4*DIGITS).

Ports:
- i_clk  input  1  system clock (48 MHz); all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_bin  input  IN_W  unsigned binary value to convert.
- i_valid  input  1  i_bin is valid this cycle.
- o_ready  output  1  block is idle and will accept i_bin when i_valid=1.
- o_bcd  output  4*DIGITS  packed BCD result; least-significant digit in [3:0].
- o_valid  output  1  one-cycle pulse: o_bcd updated this cycle.
- o_overflow  output  1  held with o_bcd: converted value > 10^DIGITS - 1.

Behaviour:
- Internal localparam FULL_DIGITS = (IN_W*301)/1000 + 1 (8 -> 3); the scratch BCD register is 4*FULL_DIGITS bits, so any IN_W value converts exactly.
- Reset (i_rst=1 at an edge): state=IDLE, o_bcd=0, o_valid=0, o_overflow=0, scratch and counter cleared, o_ready=1 from the first cycle after reset.
- o_ready is high iff state==IDLE.
- FSM states:
  - IDLE: on i_valid & o_ready, latch i_bin into the shift register, clear scratch, set bit counter to IN_W, go to SHIFT. i_valid without a handshake has no effect.
  - SHIFT: each cycle, in order: add 3 to every scratch digit >= 5, then shift {scratch, shift} left by 1 and decrement the counter. When the counter reaches 0 after a shift, go to DONE.
  - DONE: load o_bcd from the low DIGITS digits of scratch (see Optional Feature), set o_overflow if any higher scratch digit is nonzero, pulse o_valid=1 for this cycle only, then return to IDLE.
- Latency: handshake at edge N; o_valid=1 during cycle N+IN_W+1; o_ready=1 again in cycle N+IN_W+2. Throughput: one conversion per IN_W+2 cycles.
- i_valid and i_bin are ignored while not IDLE. No queueing: values presented while busy are dropped, and the upstream must hold i_valid until o_ready.
- o_bcd and o_overflow hold their last values between conversions.
- Reset mid-conversion aborts the conversion with no o_valid pulse; all outputs return to their reset values.
- IN_W=1 is legal: one SHIFT cycle.
- If DIGITS >= FULL_DIGITS, o_overflow is constant 0 and the extra high digits of o_bcd are 0.

Optional Feature:
- Macro BIN_TO_BCD_SATURATE_EN.
- Defined: on overflow, o_bcd is all digits 9 (e.g. 8'h99 for DIGITS=2).
- Undefined: on overflow, o_bcd holds the low DIGITS digits (value mod 10^DIGITS).
- o_overflow behaves identically in both builds.

Decomposition:
- Shared package bcd_pkg:
  - localparam BCD_DIGIT_W=4.
  - Function bcd_full_digits(in_w) returning FULL_DIGITS.
  - Constant BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
- One natural sub-module, bcd_digit_adjust: combinational 4-bit "add 3 if >= 5", instantiated FULL_DIGITS times via generate.
- FSM and counter stay in bin_to_bcd.

Test Plan:
- Reset, then i_bin=42 with i_valid held one cycle -> o_valid pulse exactly 9 cycles later, o_bcd=8'h42, o_overflow=0, o_ready low for 10 cycles.
- Sweep i_bin 0..99 back-to-back, each sent when o_ready -> o_bcd equals decimal digits of input every time; o_overflow=0 throughout.
- i_bin=100 and 255 -> o_overflow=1. With the macro defined: o_bcd=8'h99 both times. Without it: o_bcd=8'h00 and 8'h55.
- i_bin=7 accepted, then i_valid=1 with i_bin=88 during SHIFT -> single o_valid pulse with o_bcd=8'h07; 88 is not converted.
- i_bin=63 accepted, i_rst pulsed 4 cycles later -> no o_valid pulse, o_bcd=0, o_ready=1 next cycle. A following i_bin=12 yields 8'h12.
- Parameter variant IN_W=16, DIGITS=5, i_bin=65535 -> o_bcd=20'h65535, o_overflow=0, latency 17 cycles.
